digi_ota_array: RTL and testbench
=================================

# digi_ota_array

Clocked, multi-channel successor to the gate-level digital OTA. Each channel samples a digitised differential pair (vip/vin), resolves it into drive-high, drive-low or release, and drives a tri-stated output pad with break-before-make dead time. A mode input selects direct comparison or an integrating (transconductance-like) up/down accumulator with hysteresis. Sits between the ua/ui input pads and the uio_out/uio_oe pad pairs of the tile top.

## Interface
- CHANNELS, 2: number of independent OTA channels (1..8).
- CNT_W, 4: accumulator width in integrate mode (3..8); MID = 2^(CNT_W-1).
- HYST, 2: hysteresis band half-width; 1 ≤ HYST < MID.
- DEAD_CYC, 2: release cycles inserted on drive-polarity reversal (0..15; 0 = none).

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; low forces every channel to release and accumulators to MID.
- mode  in  1  0 = direct, 1 = integrate.
- vip  in  CHANNELS  positive input per channel, asynchronous.
- vin  in  CHANNELS  negative input per channel, asynchronous.
- out  out  CHANNELS  pad data (meaningful only when oe=1).
- oe  out  CHANNELS  pad output enable, 1 = driving.
- sat  out  CHANNELS  1 when accumulator is at 0 or 2^CNT_W-1.

## Operation
- Per channel, vip/vin pass through a 2-flop synchroniser (vip_s, vin_s); reset value 0.
- Decision: UP = vip_s & ~vin_s; DN = vin_s & ~vip_s; equal inputs = NONE.
- Direct mode target: UP→HI, DN→LO, NONE→Z.
- Integrate mode: acc (CNT_W bits, reset MID) +1 on UP, -1 on DN, holds on NONE; saturates at 0 and 2^CNT_W-1, never wraps. Target HI if acc ≥ MID+HYST, LO if acc ≤ MID-HYST, else Z.
- Output FSM states: REL (out=0, oe=0), DHI (out=1, oe=1), DLO (out=0, oe=1), DEAD (out=0, oe=0, counter dcnt).
- REL→DHI/DLO directly when target HI/LO.
- DHI/DLO→REL immediately on target Z.
- DHI→DLO or DLO→DHI: enter DEAD with dcnt=DEAD_CYC-1; if DEAD_CYC=0 switch directly.
- DEAD: decrement each cycle; on dcnt=0 go to the state for the target at that cycle (DHI, DLO or REL). Target changes during DEAD do not restart the count.
- en=0: next edge all channels to REL, acc to MID, dcnt to 0; synchronisers keep running.
- mode change (detected on registered mode): acc reloads MID on that edge; FSM continues with the new-mode target from the next cycle, still honouring dead time.
- sat = (acc==0)|(acc==2^CNT_W-1), registered from acc; 0 in direct mode.

## Timing
- Reset (async assert, sync-safe deassert expected upstream): out=0, oe=0, sat=0, acc=MID, FSM=REL, synchronisers 0, registered mode=0.
- Direct: input stable before edge E0 → vip_s at E1 → out/oe valid after E2 (2-cycle latency from REL).
- Integrate: acc updates after E2, out/oe after E3; reaching threshold from MID takes HYST decisions.
- Reversal adds exactly DEAD_CYC cycles of oe=0 between opposite drives; oe never rises with out opposite to the previous drive without DEAD.
- Channels are fully independent; no cross-channel ordering.

## Structure
- Package digi_ota_pkg: FSM state encoding (REL, DHI, DLO, DEAD), target encoding (T_Z, T_HI, T_LO), parameter-range check helpers.
- Sub-module digi_ota_channel (synchroniser, decision, accumulator, FSM) generated CHANNELS times; top holds only mode register, en fan-out and port packing.

## Test plan
Params CHANNELS=2, CNT_W=4 (MID=8), HYST=2, DEAD_CYC=2.
- Reset then mode=0, en=1, vip[0]=1, vin[0]=0 before E0 → out[0]=1, oe[0]=1 after E2; ch1 stays oe=0.
- Direct, ch0 in DHI, switch to vip=0, vin=1 → oe=0 for exactly 2 cycles, then out=0, oe=1.
- Integrate, UP held → acc 8→9→10, oe=1 out=1 the cycle after acc=10; hold UP 6 more cycles → acc=15, sat=1, no wrap.
- Integrate, acc=10, DN for 3 cycles → acc=7, oe=0 (Z) once acc=9; further DN to 6 → DEAD not entered (from REL), out=0, oe=1.
- Mid-DEAD, drop en=0 → next edge REL, acc=8, oe=0; raise en with vip=vin=1 → stays REL.
- Assert rst asynchronously while DHI → out=0, oe=0 immediately, before next clk edge.

Source files
------------

// File: rtl/digi_ota_pkg.sv
// Shared types and helpers for the multi-channel digital OTA array.
package digi_ota_pkg;

  typedef enum logic [1:0] {
    REL  = 2'd0,
    DHI  = 2'd1,
    DLO  = 2'd2,
    DEAD = 2'd3
  } ota_state_e;

  typedef enum logic [1:0] {
    T_Z  = 2'd0,
    T_HI = 2'd1,
    T_LO = 2'd2
  } ota_tgt_e;

  localparam int unsigned DCNT_W = 4;

  // Drive state that realises a given target.
  function automatic ota_state_e state_for(input ota_tgt_e t);
    case (t)
      T_HI:    return DHI;
      T_LO:    return DLO;
      default: return REL;
    endcase
  endfunction

  function automatic bit cfg_ok(input int unsigned ch, input int unsigned cnt_w,
                                input int unsigned hyst, input int unsigned dead);
    return (ch >= 1) && (ch <= 8) && (cnt_w >= 3) && (cnt_w <= 8) &&
           (hyst >= 1) && (hyst < (1 << (cnt_w - 1))) && (dead <= 15);
  endfunction

endpackage

// File: rtl/digi_ota_channel.sv
// One OTA channel: input synchroniser, decision, integrating accumulator and
// tri-state drive FSM with break-before-make dead time.
module digi_ota_channel
  import digi_ota_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned HYST     = 2,
  parameter int unsigned DEAD_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic mode,
  input  logic mode_chg,
  input  logic vip,
  input  logic vin,
  output logic out,
  output logic oe,
  output logic sat
);

  localparam int unsigned MID = 1 << (CNT_W - 1);
  localparam logic [CNT_W-1:0] ACC_MID   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] ACC_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ACC_HI_TH = CNT_W'(MID + HYST);
  localparam logic [CNT_W-1:0] ACC_LO_TH = CNT_W'(MID - HYST);
  localparam logic [DCNT_W-1:0] DCNT_LOAD =
    (DEAD_CYC > 0) ? DCNT_W'(DEAD_CYC - 1) : DCNT_W'(0);

  logic vip_m_q, vip_m_d, vip_s_q, vip_s_d;
  logic vin_m_q, vin_m_d, vin_s_q, vin_s_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  ota_state_e state_q, state_d;
  logic out_q, out_d, oe_q, oe_d, sat_q, sat_d;
  logic up_c, dn_c;
  ota_tgt_e tgt_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vip_m_q <= 1'b0;
      vip_s_q <= 1'b0;
      vin_m_q <= 1'b0;
      vin_s_q <= 1'b0;
      acc_q   <= ACC_MID;
      dcnt_q  <= '0;
      state_q <= REL;
      out_q   <= 1'b0;
      oe_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      vip_m_q <= vip_m_d;
      vip_s_q <= vip_s_d;
      vin_m_q <= vin_m_d;
      vin_s_q <= vin_s_d;
      acc_q   <= acc_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    vip_m_d = vip;
    vip_s_d = vip_m_q;
    vin_m_d = vin;
    vin_s_d = vin_m_q;
    up_c    = vip_s_q & ~vin_s_q;
    dn_c    = vin_s_q & ~vip_s_q;
    acc_d   = acc_q;
    tgt_c   = T_Z;
    state_d = state_q;
    dcnt_d  = dcnt_q;

    // Accumulator only integrates in a settled integrate mode; otherwise parked at MID.
    if (!en || !mode || mode_chg) begin
      acc_d = ACC_MID;
    end else if (up_c && (acc_q != ACC_MAX)) begin
      acc_d = acc_q + CNT_W'(1);
    end else if (dn_c && (acc_q != '0)) begin
      acc_d = acc_q - CNT_W'(1);
    end

    if (mode) begin
      if (acc_q >= ACC_HI_TH)      tgt_c = T_HI;
      else if (acc_q <= ACC_LO_TH) tgt_c = T_LO;
    end else begin
      if (up_c)      tgt_c = T_HI;
      else if (dn_c) tgt_c = T_LO;
    end

    case (state_q)
      REL: state_d = state_for(tgt_c);
      DHI: begin
        if (tgt_c == T_Z) begin
          state_d = REL;
        end else if (tgt_c == T_LO) begin
          if (DEAD_CYC == 0) begin
            state_d = DLO;
          end else begin
            state_d = DEAD;
            dcnt_d  = DCNT_LOAD;
          end
        end
      end
      DLO: begin
        if (tgt_c == T_Z) begin
          state_d = REL;
        end else if (tgt_c == T_HI) begin
          if (DEAD_CYC == 0) begin
            state_d = DHI;
          end else begin
            state_d = DEAD;
            dcnt_d  = DCNT_LOAD;
          end
        end
      end
      default: begin
        if (dcnt_q == '0) state_d = state_for(tgt_c);
        else              dcnt_d  = dcnt_q - DCNT_W'(1);
      end
    endcase

    if (!en) begin
      state_d = REL;
      dcnt_d  = '0;
    end

    out_d = (state_d == DHI);
    oe_d  = (state_d == DHI) || (state_d == DLO);
    sat_d = mode && ((acc_d == '0) || (acc_d == ACC_MAX));
  end

  assign out = out_q;
  assign oe  = oe_q;
  assign sat = sat_q;

endmodule

// File: rtl/digi_ota_array.sv
// Multi-channel clocked digital OTA: registers mode, fans out enable and
// packs the per-channel pad outputs.
module digi_ota_array
  import digi_ota_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned HYST     = 2,
  parameter int unsigned DEAD_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [CHANNELS-1:0] vip,
  input  logic [CHANNELS-1:0] vin,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] oe,
  output logic [CHANNELS-1:0] sat
);

  if (!cfg_ok(CHANNELS, CNT_W, HYST, DEAD_CYC)) begin : g_bad_cfg
    $error("digi_ota_array: parameter out of range");
  end

  logic mode_q, mode_d;
  logic mode_chg_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= 1'b0;
    else     mode_q <= mode_d;
  end

  // Change is seen on the edge that updates the registered mode.
  always_comb begin
    mode_d     = mode;
    mode_chg_c = (mode != mode_q);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    digi_ota_channel #(
      .CNT_W    (CNT_W),
      .HYST     (HYST),
      .DEAD_CYC (DEAD_CYC)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode_q),
      .mode_chg (mode_chg_c),
      .vip      (vip[i]),
      .vin      (vin[i]),
      .out      (out[i]),
      .oe       (oe[i]),
      .sat      (sat[i])
    );
  end

endmodule

// File: tb/tb_digi_ota_array.sv
// Directed table-driven bench for digi_ota_array (2 channels, MID=8, HYST=2, DEAD_CYC=2).
module tb_digi_ota_array;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] vip = 2'b00;
  logic [1:0] vin = 2'b00;
  logic [1:0] out, oe, sat;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic       mode;
    logic [1:0] vip;
    logic [1:0] vin;
    logic [1:0] out;
    logic [1:0] oe;
    logic [1:0] sat;
  } vec_t;

  vec_t vecs [12];

  digi_ota_array #(
    .CHANNELS (2),
    .CNT_W    (4),
    .HYST     (2),
    .DEAD_CYC (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .vip  (vip),
    .vin  (vin),
    .out  (out),
    .oe   (oe),
    .sat  (sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic m);
    rst  = 1'b1;
    en   = 1'b0;
    mode = m;
    vip  = 2'b00;
    vin  = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    vecs[1]  = '{1'b1, 1'b0, 2'b01, 2'b10, 2'b01, 2'b11, 2'b00};
    vecs[2]  = '{1'b1, 1'b0, 2'b10, 2'b01, 2'b10, 2'b11, 2'b00};
    vecs[3]  = '{1'b1, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    vecs[4]  = '{1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00};
    vecs[5]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[6]  = '{1'b1, 1'b0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[8]  = '{1'b1, 1'b1, 2'b01, 2'b10, 2'b01, 2'b11, 2'b11};
    vecs[9]  = '{1'b1, 1'b1, 2'b10, 2'b01, 2'b10, 2'b11, 2'b11};
    vecs[10] = '{1'b1, 1'b1, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11};
    vecs[11] = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};

    // Reset state
    #2;
    chk("rst_out", out, 2'b00);
    chk("rst_oe", oe, 2'b00);
    chk("rst_sat", sat, 2'b00);

    // Direct mode: two-cycle latency from REL
    do_reset(1'b0);
    en = 1'b1; vip = 2'b01; vin = 2'b00;
    tick(); chk("dir_e0_oe", oe, 2'b00);
    tick(); chk("dir_e1_oe", oe, 2'b00);
    tick(); chk("dir_e2_oe", oe, 2'b01); chk("dir_e2_out", out, 2'b01);

    // Reversal HI->LO with two dead cycles
    vip = 2'b00; vin = 2'b01;
    tick(); chk("rev_f0_oe", oe, 2'b01);
    tick(); chk("rev_f1_oe", oe, 2'b01); chk("rev_f1_out", out, 2'b01);
    tick(); chk("rev_f2_dead_oe", oe, 2'b00);
    tick(); chk("rev_f3_dead_oe", oe, 2'b00);
    tick(); chk("rev_f4_oe", oe, 2'b01); chk("rev_f4_out", out, 2'b00);

    // Reverse again, drop en in the middle of DEAD
    vip = 2'b01; vin = 2'b00;
    tick(); tick(); chk("rev2_g1_oe", oe, 2'b01);
    tick(); chk("rev2_g2_dead_oe", oe, 2'b00);
    en = 1'b0; vip = 2'b11; vin = 2'b11;
    tick(); chk("en0_rel_oe", oe, 2'b00); chk("en0_rel_out", out, 2'b00);
    tick(); en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); chk("en1_none_oe", oe, 2'b00);
    end

    // Integrate: UP held, threshold after HYST steps, saturate without wrap
    do_reset(1'b1);
    en = 1'b1; vip = 2'b01; vin = 2'b00;
    tick(); tick(); tick();
    tick(); chk("int_e3_oe", oe, 2'b00);
    tick(); chk("int_e4_oe", oe, 2'b01); chk("int_e4_out", out, 2'b01); chk("int_e4_sat", sat, 2'b00);
    tick(); tick(); tick();
    chk("int_e7_sat", sat, 2'b00);
    tick(); chk("int_e8_sat", sat, 2'b01);
    tick(); chk("int_e9_sat", sat, 2'b01); chk("int_e9_oe", oe, 2'b01); chk("int_e9_out", out, 2'b01);

    // Async reset while driving high
    #2 rst = 1'b1;
    #1;
    chk("arst_out", out, 2'b00); chk("arst_oe", oe, 2'b00); chk("arst_sat", sat, 2'b00);

    // Integrate: two UP then DN; release at acc=9, drive low from REL at acc=6
    do_reset(1'b1);
    en = 1'b1; vip = 2'b01; vin = 2'b00;
    tick(); tick();
    vip = 2'b00; vin = 2'b01;
    tick();
    tick(); chk("dn_e3_oe", oe, 2'b00);
    tick(); chk("dn_e4_oe", oe, 2'b01); chk("dn_e4_out", out, 2'b01);
    tick(); chk("dn_e5_oe", oe, 2'b00);
    tick(); chk("dn_e6_oe", oe, 2'b00);
    tick(); chk("dn_e7_oe", oe, 2'b00);
    tick(); chk("dn_e8_oe", oe, 2'b01); chk("dn_e8_out", out, 2'b00);

    // Steady-state table
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      en = vecs[i].en; mode = vecs[i].mode; vip = vecs[i].vip; vin = vecs[i].vin;
      repeat (24) tick();
      chk($sformatf("vec%0d_out", i), out, vecs[i].out);
      chk($sformatf("vec%0d_oe", i), oe, vecs[i].oe);
      chk($sformatf("vec%0d_sat", i), sat, vecs[i].sat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
